tiny_rv_fetch: RTL and testbench
================================

// Module: tiny_rv_fetch
// PURPOSE
//  Instruction fetch stage of tiny_rv core; producer side of the fetch->decode interface.
//  Holds the PC and issues word reads on the instruction-memory req/gnt/rvalid bus.
//  Presents fetch_pc/fetch_inst to tiny_rv_decode, honouring i_pipe_stall/i_pipe_flush.
//  Injects a NOP bubble whenever no instruction is available.
//  Max one outstanding memory read; peak throughput 1 instruction / 2 cycles.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC of the first fetch after reset
// PORTS
//  i_clk            in   1   clock
//  i_reset_n        in   1   reset, asynchronous, active-low
//  i_pipe_stall     in   1   hold fetch outputs (decode not accepting)
//  i_pipe_flush     in   1   redirect: discard all fetched/in-flight work
//  i_redirect_pc    in   32  new PC, sampled when i_pipe_flush=1; bits[1:0] ignored
//  o_imem_req       out  1   read request valid
//  o_imem_addr      out  32  word-aligned read address, [1:0]=0
//  i_imem_gnt       in   1   request accepted this cycle (meaningful only with req)
//  i_imem_rvalid    in   1   read data valid; >=1 cycle after gnt, in order
//  i_imem_rdata     in   32  instruction word
//  fetch_pc         out  32  PC of fetch_inst (registered)
//  fetch_inst       out  32  instruction or bubble (registered)
//  fetch_valid      out  1   fetch_inst is a real instruction
// BEHAVIOUR
//  Reset (async): state=IDLE, pc_q=RESET_PC, buf empty, fetch_pc=0, fetch_inst=`RV_NOP,
//   fetch_valid=0, o_imem_req=0. First edge after deassert: IDLE->REQ.
//  o_imem_req = (state==REQ) && !i_pipe_flush && (!buf_valid || !i_pipe_stall).
//   o_imem_addr = {pc_q[31:2],2'b00}; req/addr held stable until gnt.
//  REQ:   req&&gnt -> pc_q<=pc_q+4 (mod 2^32, wraps FFFF_FFFC->0), ->WAIT.
//  WAIT:  rvalid -> buf<={addr_of_req, rdata}, buf_valid=1, ->REQ.
//  DRAIN: rvalid -> data dropped, ->REQ. No req issued in DRAIN.
//  Output regs update only when !i_pipe_stall: buf_valid -> load buf, clear buf,
//   fetch_valid=1; else load bubble (pc=0, inst=`RV_NOP, valid=0). Stall: all held.
//  Buffer never overflows: req only when buf empty or draining this cycle; rvalid
//   >=1 cycle after gnt. rvalid in REQ/IDLE is a protocol error (assert).
//  Flush (priority over stall; same cycle counts): pc_q<={i_redirect_pc[31:2],2'b00},
//   buf_valid=0, outputs <= bubble. State: IDLE/REQ->REQ; WAIT w/o rvalid->DRAIN;
//   WAIT with rvalid -> data dropped, ->REQ; DRAIN w/o rvalid stays, with rvalid->REQ.
//  Latency: gnt cycle N, rvalid N+k (k>=1) -> fetch_valid at N+k+1 if not stalled.
//  Reset mid-transaction: in-flight response after reset is in IDLE/REQ -> ignored,
//   memory side must also be reset.
// STRUCTURE
//  rv_opcodes.sv: add `RV_NOP 32'h0000_0013 (addi x0,x0,0).
//  tiny_rv_pkg: fetch_state_t enum {IDLE,REQ,WAIT,DRAIN}; IMEM_ADDR_W=32.
//  One sub-module: tiny_rv_fetch_buf (1-entry pc/inst buffer: wr, rd, clr, valid).
//  FSM, pc_q and output registers remain in tiny_rv_fetch.
// TESTING
//  1 Reset release, gnt=1 always, rvalid 1 cycle after gnt -> addrs 0,4,8..;
//    fetch_valid every 2nd cycle, fetch_pc 0,4,8 with matching rdata.
//  2 Stall held 5 cycles while response pending -> inst captured in buf, req low;
//    after release fetch_pc continues with no skip or duplicate.
//  3 Flush in WAIT, redirect 0x0000_1002 -> late rvalid dropped (never output);
//    next req addr 0x0000_1000, fetch_pc 0x1000.
//  4 Flush+stall same cycle -> outputs become bubble (valid=0, inst=0x13), buf cleared.
//  5 gnt held low 10 cycles -> req/addr stable; rvalid delay 4 -> fetch_valid 5 cycles after gnt.
//  6 RESET_PC=32'hFFFF_FFFC -> second request addr 0x0000_0000; async reset mid-WAIT
//    -> outputs zero/NOP immediately, req=0.

Source files
------------

// File: rtl/tiny_rv_pkg.sv
// Shared types and constants for the tiny_rv core.
`ifndef RV_NOP
`define RV_NOP 32'h0000_0013
`endif

package tiny_rv_pkg;

  localparam int IMEM_ADDR_W = 32;

  // Instruction word presented to decode whenever no real instruction is available
  localparam logic [31:0] NOP_INST = `RV_NOP;

  // Fetch FSM:
  //   IDLE  - one cycle after reset, no request
  //   REQ   - presenting (or ready to present) a read request
  //   WAIT  - one read outstanding, its data is wanted
  //   DRAIN - one read outstanding, its data will be discarded (flushed)
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/rv_opcodes.sv
// Shared RISC-V opcode constants for the tiny_rv core.
`ifndef RV_OPCODES_SV
`define RV_OPCODES_SV
// Canonical NOP: addi x0, x0, 0
`define RV_NOP 32'h0000_0013
`endif

// File: rtl/tiny_rv_fetch_buf.sv
// One-entry pc/instruction holding buffer. Catches a read response that
// arrives while decode is stalled so it is not lost.
module tiny_rv_fetch_buf
  import tiny_rv_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr,
  input  logic [IMEM_ADDR_W-1:0] wr_pc,
  input  logic [31:0]            wr_inst,
  input  logic                   rd,
  input  logic                   clr,
  output logic                   valid,
  output logic [IMEM_ADDR_W-1:0] pc,
  output logic [31:0]            inst
);

  // Occupancy flag: clear beats write, write beats read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (wr) begin
      valid <= 1'b1;
    end else if (rd) begin
      valid <= 1'b0;
    end
  end

  // Payload storage, captured on write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc   <= '0;
      inst <= NOP_INST;
    end else if (wr && !clr) begin
      pc   <= wr_pc;
      inst <= wr_inst;
    end
  end

endmodule

// File: rtl/tiny_rv_fetch.sv
// Instruction fetch stage of the tiny_rv core. Issues word reads on the
// req/gnt/rvalid instruction bus (at most one outstanding) and presents
// pc/instruction pairs, or NOP bubbles, to decode.
//
// Handshakes:
//   memory request : a read is accepted on a cycle with o_imem_req && i_imem_gnt;
//                    req and addr stay stable until that cycle unless a flush
//                    or a full buffer under stall withdraws the request.
//                    i_imem_rvalid returns data in order, at least one cycle later.
//   decode         : fetch_* advance on every cycle without i_pipe_stall; a
//                    stall freezes them. Flush overrides stall.
module tiny_rv_fetch
  import tiny_rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_pipe_stall,
  input  logic        i_pipe_flush,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_inst,
  output logic        fetch_valid,
  output logic [1:0]  dbg_state
);

  fetch_state_t state_q, state_d;
  logic [31:2]  pc_q;
  logic [31:2]  req_addr_q;

  logic         hs;
  logic         rsp_live;
  logic         rsp_direct;
  logic         buf_wr;
  logic         buf_rd;
  logic         buf_valid;
  logic [31:0]  buf_pc;
  logic [31:0]  buf_inst;
  logic         unused_redirect;

  // The low redirect bits carry no meaning for word fetches.
  assign unused_redirect = ^i_redirect_pc[1:0];

  assign dbg_state   = state_q;
  assign o_imem_req  = (state_q == REQ) && !i_pipe_flush && (!buf_valid || !i_pipe_stall);
  assign o_imem_addr = {pc_q, 2'b00};
  assign hs          = o_imem_req && i_imem_gnt;

  // A response is wanted only in WAIT and only if this cycle does not flush.
  // It goes straight to the output registers when decode is moving and
  // nothing older is buffered; otherwise it parks in the buffer.
  assign rsp_live   = (state_q == WAIT) && i_imem_rvalid && !i_pipe_flush;
  assign rsp_direct = rsp_live && !i_pipe_stall && !buf_valid;
  assign buf_wr     = rsp_live && !rsp_direct;
  assign buf_rd     = buf_valid && !i_pipe_stall && !i_pipe_flush;

  tiny_rv_fetch_buf u_buf (
    .clk     (i_clk),
    .rst_n   (i_reset_n),
    .wr      (buf_wr),
    .wr_pc   ({req_addr_q, 2'b00}),
    .wr_inst (i_imem_rdata),
    .rd      (buf_rd),
    .clr     (i_pipe_flush),
    .valid   (buf_valid),
    .pc      (buf_pc),
    .inst    (buf_inst)
  );

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a flush while a read is pending turns WAIT into DRAIN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = REQ;
      REQ:     if (hs) state_d = WAIT;
      WAIT: begin
        if (i_imem_rvalid)     state_d = REQ;
        else if (i_pipe_flush) state_d = DRAIN;
      end
      DRAIN:   if (i_imem_rvalid) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  // Program counter: redirect on flush, advance by one word per accepted read.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pc_q <= RESET_PC[31:2];
    end else if (i_pipe_flush) begin
      pc_q <= i_redirect_pc[31:2];
    end else if (hs) begin
      pc_q <= pc_q + 30'd1;
    end
  end

  // Address of the outstanding read, paired with its returning data.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      req_addr_q <= '0;
    end else if (hs) begin
      req_addr_q <= pc_q;
    end
  end

  // Decode-facing registers: bubble on flush, frozen on stall, otherwise
  // buffered entry first, then a direct response, else a bubble.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      fetch_valid <= 1'b0;
      fetch_pc    <= '0;
      fetch_inst  <= NOP_INST;
    end else if (i_pipe_flush) begin
      fetch_valid <= 1'b0;
      fetch_pc    <= '0;
      fetch_inst  <= NOP_INST;
    end else if (!i_pipe_stall) begin
      if (buf_valid) begin
        fetch_valid <= 1'b1;
        fetch_pc    <= buf_pc;
        fetch_inst  <= buf_inst;
      end else if (rsp_direct) begin
        fetch_valid <= 1'b1;
        fetch_pc    <= {req_addr_q, 2'b00};
        fetch_inst  <= i_imem_rdata;
      end else begin
        fetch_valid <= 1'b0;
        fetch_pc    <= '0;
        fetch_inst  <= NOP_INST;
      end
    end
  end

  // Read data may only arrive while a read is outstanding.
  a_no_stray_rvalid: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    !(i_imem_rvalid && (state_q == IDLE || state_q == REQ)));

endmodule

// File: tb/tb_tiny_rv_fetch.sv
// Bench for tiny_rv_fetch: a bus responder plus a transaction-level model
// (expected request address, one outstanding read, queue of instructions
// not yet handed to decode) checked every cycle, plus scenario checks.
module tb_tiny_rv_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, stall, flush;
  logic [31:0] redirect;
  logic        req, gnt, rvalid;
  logic [31:0] addr, rdata;
  logic [31:0] f_pc, f_inst;
  logic        f_valid;
  logic [1:0]  dbg;

  tiny_rv_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_pipe_stall(stall), .i_pipe_flush(flush),
    .i_redirect_pc(redirect), .o_imem_req(req), .o_imem_addr(addr),
    .i_imem_gnt(gnt), .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
    .fetch_pc(f_pc), .fetch_inst(f_inst), .fetch_valid(f_valid), .dbg_state(dbg)
  );

  // Second instance for the wrap-around reset PC.
  logic        w_reset_n, w_stall, w_flush, w_req, w_gnt, w_rvalid, w_fv;
  logic [31:0] w_redirect, w_addr, w_rdata, w_pc, w_inst;
  logic [1:0]  w_dbg;

  tiny_rv_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .i_clk(clk), .i_reset_n(w_reset_n), .i_pipe_stall(w_stall), .i_pipe_flush(w_flush),
    .i_redirect_pc(w_redirect), .o_imem_req(w_req), .o_imem_addr(w_addr),
    .i_imem_gnt(w_gnt), .i_imem_rvalid(w_rvalid), .i_imem_rdata(w_rdata),
    .fetch_pc(w_pc), .fetch_inst(w_inst), .fetch_valid(w_fv), .dbg_state(w_dbg)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model state ----------------
  logic [63:0] exp_q[$];          // {pc, inst} received but not yet shown to decode
  logic        m_valid;
  logic [31:0] m_pc, m_inst;
  logic        ost, ost_live;     // one read outstanding; whether its data is wanted
  logic [31:0] ost_addr;
  int          ost_cnt;
  logic [31:0] exp_pc;
  logic        first_cyc;
  int          gnt_pct, lat_min, lat_max;

  // per-cycle observations for scenario tasks
  int          cyc;
  logic        hs_seen, acc_seen, obs_req;
  logic [31:0] hs_addr, acc_pc, obs_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- driver: one bus cycle, model-checked ----------------
  task automatic cycle();
    logic        exp_req, hs, rv;
    logic [31:0] rd;
    acc_seen = f_valid && !stall;
    acc_pc   = f_pc;
    gnt    = ($urandom_range(0, 99) < gnt_pct);
    rv     = ost && (ost_cnt == 0);
    rd     = rv ? mem_word(ost_addr) : $urandom;
    rvalid = rv;
    rdata  = rd;
    #1;
    exp_req = !ost && !flush && !((exp_q.size() > 0) && stall) && !first_cyc;
    checks++;
    if (req !== exp_req) begin
      errors++;
      $display("FAIL req: got %b expected %b (cycle %0d)", req, exp_req, cyc);
    end
    if (exp_req) begin
      checks++;
      if (addr !== exp_pc) begin
        errors++;
        $display("FAIL req_addr: got %h expected %h (cycle %0d)", addr, exp_pc, cyc);
      end
    end
    obs_req  = req;
    obs_addr = addr;
    hs       = req && gnt;
    hs_seen  = hs;
    hs_addr  = addr;
    // decode-side model
    if (flush) begin
      exp_q.delete();
      m_valid = 1'b0; m_pc = '0; m_inst = NOP;
    end else begin
      if (rv && ost_live) exp_q.push_back({ost_addr, rd});
      if (!stall) begin
        if (exp_q.size() > 0) begin
          {m_pc, m_inst} = exp_q.pop_front();
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0; m_pc = '0; m_inst = NOP;
        end
      end
    end
    // memory-side model
    if (rv) ost = 1'b0;
    else if (ost) ost_cnt--;
    if (flush) ost_live = 1'b0;
    if (flush) exp_pc = {redirect[31:2], 2'b00};
    else if (hs) exp_pc = exp_pc + 32'd4;
    if (hs) begin
      ost = 1'b1; ost_live = 1'b1; ost_addr = addr;
      ost_cnt = int'($urandom_range(lat_min, lat_max)) - 1;
    end
    first_cyc = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks += 3;
    if (f_valid !== m_valid) begin
      errors++;
      $display("FAIL fetch_valid: got %b expected %b (cycle %0d)", f_valid, m_valid, cyc);
    end
    if (f_pc !== m_pc) begin
      errors++;
      $display("FAIL fetch_pc: got %h expected %h (cycle %0d)", f_pc, m_pc, cyc);
    end
    if (f_inst !== m_inst) begin
      errors++;
      $display("FAIL fetch_inst: got %h expected %h (cycle %0d)", f_inst, m_inst, cyc);
    end
    cyc++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect = '0;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (req !== 1'b0)   begin errors++; $display("FAIL reset_req: got %b expected 0", req); end
    if (f_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", f_valid); end
    if (f_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", f_pc); end
    if (f_inst !== NOP) begin errors++; $display("FAIL reset_inst: got %h expected %h", f_inst, NOP); end
    exp_q.delete();
    m_valid = 1'b0; m_pc = '0; m_inst = NOP;
    ost = 1'b0; ost_live = 1'b0; ost_addr = '0; ost_cnt = 0;
    exp_pc = 32'h0; first_cyc = 1'b1; cyc = 0;
    reset_n = 1'b1;
  endtask

  task automatic test_sequential();
    logic [31:0] hs_list[$];
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (hs_seen) hs_list.push_back(hs_addr);
      checks++;
      if (f_valid !== (i >= 2 && (i % 2) == 0)) begin
        errors++;
        $display("FAIL seq_valid_pattern: got %b at step %0d", f_valid, i);
      end
      if (i >= 2 && (i % 2) == 0) begin
        checks++;
        if (f_pc !== 32'(2 * (i - 2))) begin
          errors++;
          $display("FAIL seq_pc: got %h expected %h", f_pc, 32'(2 * (i - 2)));
        end
      end
    end
    checks++;
    if (hs_list.size() < 4) begin
      errors++;
      $display("FAIL seq_hs_count: got %0d expected >=4", hs_list.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (hs_list[k] !== 32'(4 * k)) begin
          errors++;
          $display("FAIL seq_addr: got %h expected %h", hs_list[k], 32'(4 * k));
        end
      end
    end
  endtask

  task automatic test_stall();
    logic        found, have_prev;
    logic [31:0] prev;
    int          n_acc;
    stall = 1'b0; flush = 1'b0; gnt_pct = 100; lat_min = 2; lat_max = 2;
    found = 1'b0; have_prev = 1'b0; prev = '0; n_acc = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      found = hs_seen;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL stall_setup: got no grant expected one"); end
    stall = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    checks++;
    if (obs_req !== 1'b0) begin
      errors++;
      $display("FAIL stall_req_low: got %b expected 0", obs_req);
    end
    stall = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (acc_seen) begin
        n_acc++;
        if (have_prev) begin
          checks++;
          if (acc_pc !== prev + 32'd4) begin
            errors++;
            $display("FAIL stall_sequence: got %h expected %h", acc_pc, prev + 32'd4);
          end
        end
        have_prev = 1'b1;
        prev = acc_pc;
      end
    end
    checks++;
    if (n_acc < 4) begin errors++; $display("FAIL stall_progress: got %0d expected >=4", n_acc); end
  endtask

  task automatic test_flush_wait();
    logic found, got_hs, got_out;
    stall = 1'b0; flush = 1'b0; gnt_pct = 100; lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      found = hs_seen;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL flush_setup: got no grant expected one"); end
    flush = 1'b1; redirect = 32'h0000_1002;
    cycle();
    flush = 1'b0;
    got_hs = 1'b0; got_out = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (hs_seen && !got_hs) begin
        got_hs = 1'b1;
        checks++;
        if (hs_addr !== 32'h0000_1000) begin
          errors++;
          $display("FAIL flush_addr: got %h expected 00001000", hs_addr);
        end
      end
      if (f_valid && !got_out) begin
        got_out = 1'b1;
        checks++;
        if (f_pc !== 32'h0000_1000) begin
          errors++;
          $display("FAIL flush_first_pc: got %h expected 00001000", f_pc);
        end
      end
    end
    checks++;
    if (!got_hs || !got_out) begin
      errors++;
      $display("FAIL flush_timeout: got hs=%b out=%b expected 1 1", got_hs, got_out);
    end
  endtask

  task automatic test_flush_stall();
    stall = 1'b0; flush = 1'b0; gnt_pct = 100; lat_min = 1; lat_max = 1;
    for (int i = 0; i < 10 && !f_valid; i++) cycle();
    checks++;
    if (f_valid !== 1'b1) begin errors++; $display("FAIL fs_setup: got %b expected 1", f_valid); end
    stall = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    checks++;
    if (f_valid !== 1'b1) begin errors++; $display("FAIL fs_hold: got %b expected 1", f_valid); end
    flush = 1'b1; redirect = 32'h0000_2000;
    cycle();
    flush = 1'b0;
    checks += 3;
    if (f_valid !== 1'b0) begin errors++; $display("FAIL fs_valid: got %b expected 0", f_valid); end
    if (f_inst !== NOP)   begin errors++; $display("FAIL fs_inst: got %h expected %h", f_inst, NOP); end
    if (f_pc !== 32'h0)   begin errors++; $display("FAIL fs_pc: got %h expected 0", f_pc); end
    for (int i = 0; i < 2; i++) cycle();
    checks++;
    if (f_valid !== 1'b0) begin errors++; $display("FAIL fs_buf_cleared: got %b expected 0", f_valid); end
    stall = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
  endtask

  task automatic test_gnt_hold();
    logic [31:0] a0;
    int          hs_cyc;
    logic        seen;
    stall = 1'b0; flush = 1'b0; gnt_pct = 0; lat_min = 4; lat_max = 4;
    for (int i = 0; i < 10 && ost; i++) cycle();
    cycle();
    a0 = obs_addr;
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if (obs_req !== 1'b1 || obs_addr !== a0) begin
        errors++;
        $display("FAIL gnt_hold_stable: got req=%b addr=%h expected 1 %h", obs_req, obs_addr, a0);
      end
    end
    gnt_pct = 100;
    hs_cyc = cyc;
    cycle();
    gnt_pct = 0;
    checks++;
    if (!hs_seen) begin errors++; $display("FAIL gnt_hold_grant: got 0 expected 1"); end
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      cycle();
      seen = f_valid;
    end
    checks++;
    if (!seen || (cyc - hs_cyc) != 5) begin
      errors++;
      $display("FAIL gnt_latency: got %0d cycles (seen=%b) expected 5", cyc - hs_cyc, seen);
    end
  endtask

  task automatic test_random();
    lat_min = 1; lat_max = 4; gnt_pct = 70;
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 99) < 30);
      flush = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 3) == 0) redirect = 32'hFFFF_FFF8 | 32'($urandom_range(0, 3));
      else redirect = $urandom;
      cycle();
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_wrap_reset();
    logic        pend;
    logic [31:0] pa;
    logic [31:0] hsa[$];
    w_stall = 1'b0; w_gnt = 1'b1; w_rvalid = 1'b0;
    pend = 1'b0; pa = '0;
    w_reset_n = 1'b1;
    for (int i = 0; i < 12 && hsa.size() < 2; i++) begin
      w_rvalid = pend;
      w_rdata  = pend ? mem_word(pa) : 32'h0;
      #1;
      @(posedge clk);
      if (w_rvalid) pend = 1'b0;
      if (w_req && w_gnt) begin
        hsa.push_back(w_addr);
        pend = 1'b1;
        pa = w_addr;
      end
      @(negedge clk);
      if (w_fv) w_stall = 1'b1;
    end
    w_rvalid = 1'b0;
    checks++;
    if (hsa.size() != 2) begin
      errors++;
      $display("FAIL wrap_hs_count: got %0d expected 2", hsa.size());
    end else begin
      checks += 2;
      if (hsa[0] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0: got %h expected fffffffc", hsa[0]); end
      if (hsa[1] !== 32'h0)         begin errors++; $display("FAIL wrap_addr1: got %h expected 0", hsa[1]); end
    end
    checks += 2;
    if (w_fv !== 1'b1) begin errors++; $display("FAIL wrap_held_valid: got %b expected 1", w_fv); end
    if (w_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_held_pc: got %h expected fffffffc", w_pc); end
    #2;
    w_reset_n = 1'b0;
    #1;
    checks += 4;
    if (w_req !== 1'b0)  begin errors++; $display("FAIL async_req: got %b expected 0", w_req); end
    if (w_fv !== 1'b0)   begin errors++; $display("FAIL async_valid: got %b expected 0", w_fv); end
    if (w_pc !== 32'h0)  begin errors++; $display("FAIL async_pc: got %h expected 0", w_pc); end
    if (w_inst !== NOP)  begin errors++; $display("FAIL async_inst: got %h expected %h", w_inst, NOP); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    w_reset_n = 1'b0; w_stall = 1'b0; w_flush = 1'b0; w_redirect = '0;
    w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = '0;
    gnt_pct = 0; lat_min = 1; lat_max = 1;
    hs_seen = 1'b0; acc_seen = 1'b0; obs_req = 1'b0;
    hs_addr = '0; acc_pc = '0; obs_addr = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_flush_wait();
    test_flush_stall();
    test_gnt_hold();
    test_random();
    test_wrap_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
